// File: rtl/sopc_test_pkg.sv
// Shared definitions for the SOPC board-test controller: FSM encoding,
// default LED verdict patterns and a small state helper.
package sopc_test_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HOLD = 3'd0;
  localparam state_t ST_RUN  = 3'd1;
  localparam state_t ST_PASS = 3'd2;
  localparam state_t ST_FAIL = 3'd3;
  localparam state_t ST_TMO  = 3'd4;

  localparam logic [3:0] DEF_PASS_PAT = 4'hA;
  localparam logic [3:0] DEF_FAIL_PAT = 4'h5;

  function automatic logic is_terminal(input state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
  endfunction

endpackage

// File: rtl/sopc_test_ctrl_if.sv
// Bundle between the test controller and the board harness: observed LEDs,
// restart request, DUT reset and the registered verdict outputs.
interface sopc_test_ctrl_if #(
  parameter int LED_W = 4,
  parameter int CNT_W = 32
);

  logic [LED_W-1:0] led;
  logic             restart;
  logic             dut_rst;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [CNT_W-1:0] cycles;

  modport master (
    input  led, restart,
    output dut_rst, done, pass, fail, timeout, cycles
  );

  modport slave (
    output led, restart,
    input  dut_rst, done, pass, fail, timeout, cycles
  );

endinterface

// File: rtl/sopc_led_stable.sv
// Two-flop synchroniser for the asynchronous LED bus followed by a
// saturating run-length counter of identical synchronised samples.
module sopc_led_stable #(
  parameter int LED_W         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [LED_W-1:0] led,
  output logic [LED_W-1:0] led_val,
  output logic             stable
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  logic [LED_W-1:0] sync1;
  logic [LED_W-1:0] sync2;
  logic [SC_W-1:0]  cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= led;
      sync2 <= sync1;
    end
  end

  // led_val is the last synchronised sample; cnt is how many consecutive
  // samples have matched it, so a verdict always pairs with its own value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_val <= '0;
      cnt     <= '0;
    end else if (clr) begin
      led_val <= '0;
      cnt     <= '0;
    end else begin
      led_val <= sync2;
      if (sync2 != led_val) begin
        cnt <= SC_W'(1);
      end else if (cnt != SC_W'(STABLE_CYCLES)) begin
        cnt <= cnt + SC_W'(1);
      end
    end
  end

  assign stable = (cnt == SC_W'(STABLE_CYCLES));

endmodule

// File: rtl/sopc_test_ctrl.sv
// Board self-test sequencer: holds the DUT in reset, runs it while watching
// its LEDs, and latches a sticky pass/fail/timeout verdict until restarted.
module sopc_test_ctrl
  import sopc_test_pkg::*;
#(
  parameter int               LED_W          = 4,
  parameter int               RST_CYCLES     = 5,
  parameter int               TIMEOUT_CYCLES = 250000,
  parameter int               STABLE_CYCLES  = 4,
  parameter logic [LED_W-1:0] PASS_PAT       = LED_W'(DEF_PASS_PAT),
  parameter logic [LED_W-1:0] FAIL_PAT       = LED_W'(DEF_FAIL_PAT),
  parameter int               CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  sopc_test_ctrl_if.master  bus
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int CMP_W  = (CNT_W > 32) ? CNT_W : 32;

  state_t           state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             stab_clr;
  logic [LED_W-1:0] led_val;
  logic             led_stable;
  logic             pass_hit, fail_hit, tmo_hit;
  logic             dut_rst_q, done_q, pass_q, fail_q, tmo_q;

  sopc_led_stable #(
    .LED_W         (LED_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clk     (clk),
    .rst     (rst),
    .clr     (stab_clr),
    .led     (bus.led),
    .led_val (led_val),
    .stable  (led_stable)
  );

  // The timeout compare is widened so a limit beyond the counter range is
  // simply never reached rather than aliasing onto a truncated value.
  assign pass_hit = led_stable && (led_val == PASS_PAT);
  assign fail_hit = led_stable && (led_val == FAIL_PAT);
  assign tmo_hit  = (CMP_W'(cyc_q) == CMP_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state;
    hold_d   = hold_cnt;
    cyc_d    = cyc_q;
    stab_clr = 1'b0;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
          cyc_d   = '0;
        end else begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (pass_hit) begin
          state_d = ST_PASS;
        end else if (fail_hit) begin
          state_d = ST_FAIL;
        end else if (tmo_hit) begin
          state_d = ST_TMO;
        end else if (!(&cyc_q)) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      ST_PASS, ST_FAIL, ST_TMO: begin
        if (bus.restart) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          cyc_d    = '0;
          stab_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        hold_d  = '0;
        cyc_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register instead of trailing it by a cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      cyc_q     <= '0;
      dut_rst_q <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state     <= state_d;
      hold_cnt  <= hold_d;
      cyc_q     <= cyc_d;
      dut_rst_q <= (state_d == ST_HOLD);
      done_q    <= is_terminal(state_d);
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      tmo_q     <= (state_d == ST_TMO);
    end
  end

  assign bus.dut_rst = dut_rst_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.timeout = tmo_q;
  assign bus.cycles  = cyc_q;

endmodule

// File: tb/tb_sopc_test_ctrl.sv
// Directed bench for sopc_test_ctrl: a short-timeout main instance plus a
// narrow-counter instance with equal pass/fail patterns.
`timescale 1ns/1ps
module tb_sopc_test_ctrl;

  logic clk;
  logic rst;
  int   check_count = 0;
  int   fail_count  = 0;
  int   hold_len;

  sopc_test_ctrl_if #(.LED_W(4), .CNT_W(32)) bus ();
  sopc_test_ctrl_if #(.LED_W(4), .CNT_W(4))  bus2 ();

  sopc_test_ctrl #(
    .LED_W(4), .RST_CYCLES(5), .TIMEOUT_CYCLES(400), .STABLE_CYCLES(4),
    .PASS_PAT(4'hA), .FAIL_PAT(4'h5), .CNT_W(32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Counter saturates at 15 well before the limit, and both patterns are 3.
  sopc_test_ctrl #(
    .LED_W(4), .RST_CYCLES(2), .TIMEOUT_CYCLES(40), .STABLE_CYCLES(4),
    .PASS_PAT(4'h3), .FAIL_PAT(4'h3), .CNT_W(4)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] led_v, input logic restart_v);
    bus.led     = led_v;
    bus.restart = restart_v;
  endtask

  task automatic pulseRestart(input logic [3:0] led_v);
    applyStimulus(led_v, 1'b1);
    tick(1);
    bus.restart = 1'b0;
  endtask

  task automatic releaseAndCountHold(output int n);
    rst = 1'b1;
    #1;
    n = 0;
    while (bus.dut_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic waitRun(output int n);
    n = 0;
    while (bus.dut_rst && n < 20) begin
      n++;
      tick(1);
    end
    checkOutput("run_entry", bus.dut_rst, 0);
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (!bus.done && n < bound) begin
      n++;
      tick(1);
    end
    checkOutput("done_reached", bus.done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no end, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(4'h0, 1'b0);
    bus2.led     = 4'h0;
    bus2.restart = 1'b0;

    #50;
    checkOutput("rst_dut_rst", bus.dut_rst, 1);
    checkOutput("rst_done",    bus.done,    0);
    checkOutput("rst_pass",    bus.pass,    0);
    checkOutput("rst_fail",    bus.fail,    0);
    checkOutput("rst_timeout", bus.timeout, 0);
    checkOutput("rst_cycles",  bus.cycles,  0);

    #50;
    releaseAndCountHold(hold_len);
    checkOutput("hold_len", hold_len, 5);
    checkOutput("run_start_cycles", bus.cycles, 0);

    // Second instance: RUN since t=120, 28 edges later its 4-bit counter sits at 15.
    tick(25);
    checkOutput("run_cycles_25", bus.cycles, 25);
    checkOutput("sat_cycles",    bus2.cycles, 15);
    checkOutput("sat_done",      bus2.done,   0);
    bus2.led = 4'h3;
    tick(7);
    checkOutput("eq_pat_pass",    bus2.pass,    1);
    checkOutput("eq_pat_fail",    bus2.fail,    0);
    checkOutput("eq_pat_timeout", bus2.timeout, 0);

    waitDone(1000);
    checkOutput("tmo_flag",   bus.timeout, 1);
    checkOutput("tmo_pass",   bus.pass,    0);
    checkOutput("tmo_fail",   bus.fail,    0);
    checkOutput("tmo_cycles", bus.cycles,  399);

    applyStimulus(4'hA, 1'b0);
    tick(20);
    checkOutput("sticky_timeout", bus.timeout, 1);
    checkOutput("sticky_pass",    bus.pass,    0);
    checkOutput("sticky_dut_rst", bus.dut_rst, 0);
    checkOutput("sticky_cycles",  bus.cycles,  399);

    pulseRestart(4'h0);
    checkOutput("rs_tmo_dut_rst", bus.dut_rst, 1);
    checkOutput("rs_tmo_done",    bus.done,    0);
    checkOutput("rs_tmo_timeout", bus.timeout, 0);
    checkOutput("rs_tmo_cycles",  bus.cycles,  0);
    waitRun(hold_len);
    checkOutput("rs_hold_len", hold_len, 5);

    tick(50);
    checkOutput("run_cycles_50", bus.cycles, 50);
    pulseRestart(4'h0);
    checkOutput("run_restart_cycles",  bus.cycles,  51);
    checkOutput("run_restart_dut_rst", bus.dut_rst, 0);
    checkOutput("run_restart_done",    bus.done,    0);
    tick(49);
    checkOutput("run_cycles_100", bus.cycles, 100);

    // 2 sync + 4 stable samples, then one registered cycle: flag 7 samples later.
    applyStimulus(4'hA, 1'b0);
    tick(6);
    checkOutput("pass_pre_done",   bus.done,   0);
    checkOutput("pass_pre_cycles", bus.cycles, 106);
    tick(1);
    checkOutput("pass_flag",    bus.pass,    1);
    checkOutput("pass_done",    bus.done,    1);
    checkOutput("pass_fail",    bus.fail,    0);
    checkOutput("pass_timeout", bus.timeout, 0);
    checkOutput("pass_cycles",  bus.cycles,  106);

    pulseRestart(4'h0);
    checkOutput("rs_pass_dut_rst", bus.dut_rst, 1);
    checkOutput("rs_pass_pass",    bus.pass,    0);
    checkOutput("rs_pass_cycles",  bus.cycles,  0);
    waitRun(hold_len);
    for (int i = 0; i < 1000 && !bus.done; i++) begin
      if (i % 2 == 0) bus.led = (bus.led == 4'hA) ? 4'h0 : 4'hA;
      tick(1);
    end
    checkOutput("toggle_done",    bus.done,    1);
    checkOutput("toggle_timeout", bus.timeout, 1);
    checkOutput("toggle_pass",    bus.pass,    0);
    checkOutput("toggle_fail",    bus.fail,    0);

    // Pattern settles during HOLD, so FAIL lands one cycle into RUN.
    pulseRestart(4'h5);
    tick(5);
    checkOutput("fail_pre_done",    bus.done,    0);
    checkOutput("fail_pre_dut_rst", bus.dut_rst, 0);
    tick(1);
    checkOutput("fail_flag",    bus.fail,    1);
    checkOutput("fail_pass",    bus.pass,    0);
    checkOutput("fail_timeout", bus.timeout, 0);
    checkOutput("fail_cycles",  bus.cycles,  0);

    pulseRestart(4'h0);
    waitRun(hold_len);
    tick(393);
    checkOutput("edge_cycles_393", bus.cycles, 393);
    applyStimulus(4'hA, 1'b0);
    tick(6);
    checkOutput("edge_pre_cycles", bus.cycles, 399);
    checkOutput("edge_pre_done",   bus.done,   0);
    tick(1);
    checkOutput("edge_pass",    bus.pass,    1);
    checkOutput("edge_timeout", bus.timeout, 0);
    checkOutput("edge_fail",    bus.fail,    0);
    checkOutput("edge_cycles",  bus.cycles,  399);

    pulseRestart(4'h0);
    checkOutput("rs_edge_done", bus.done, 0);
    waitRun(hold_len);
    tick(200);
    checkOutput("mid_cycles_200", bus.cycles, 200);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_dut_rst", bus.dut_rst, 1);
    checkOutput("async_cycles",  bus.cycles,  0);
    checkOutput("async_done2",   bus2.done,   0);
    checkOutput("async_pass2",   bus2.pass,   0);
    @(negedge clk);
    releaseAndCountHold(hold_len);
    checkOutput("rerst_hold_len", hold_len,    5);
    checkOutput("rerst_cycles",   bus.cycles,  0);
    checkOutput("rerst_done",     bus.done,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/sopc_test_ctrl.md
SOPC_TEST_CTRL -- requirements
Module: sopc_test_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 4, the width of the observed LED bus.
REQ-002 SHALL have parameter RST_CYCLES, default 5, the number of cycles dut_rst is held asserted after entering HOLD.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000, the RUN-cycle limit before a timeout verdict.
REQ-004 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical synchronised LED samples needed for a verdict.
REQ-005 SHALL have parameter PASS_PAT, default 4'hA, the LED value that signals pass.
REQ-006 SHALL have parameter FAIL_PAT, default 4'h5, the LED value that signals fail.
REQ-007 SHALL have parameter CNT_W, default 32, the cycle-counter width.
REQ-008 clk  input  1  single clock; all logic on rising edge.
REQ-009 rst  input  1  asynchronous, active-low reset.
REQ-010 led  input  LED_W  DUT LED bus, asynchronous to clk.
REQ-011 restart  input  1  single-cycle request to rerun the test.
REQ-012 dut_rst  output  1  active-high reset driven to the DUT.
REQ-013 done  output  1  high in any terminal state.
REQ-014 pass  output  1  verdict pass.
REQ-015 fail  output  1  verdict fail.
REQ-016 timeout  output  1  verdict timeout.
REQ-017 cycles  output  CNT_W  RUN cycles elapsed, frozen at verdict.

Function
REQ-018 SHALL implement FSM states HOLD, RUN, PASS, FAIL, TMO.
REQ-019 HOLD: dut_rst=1; hold counter increments; transition to RUN on the cycle the counter reaches RST_CYCLES-1, so dut_rst is high for exactly RST_CYCLES cycles.
REQ-020 RUN: dut_rst=0; cycles increments by 1 per cycle starting from 0, saturating at all-ones and never wrapping.
REQ-021 SHALL pass led through a 2-flop synchroniser; all pattern checks use the synchronised value only.
REQ-022 Stability counter: resets to 1 when the synchronised LED value differs from the previous sample, else increments, saturating at STABLE_CYCLES.
REQ-023 RUN->PASS when the stability count equals STABLE_CYCLES and the synchronised LED equals PASS_PAT; RUN->FAIL likewise with FAIL_PAT.
REQ-024 RUN->TMO when cycles equals TIMEOUT_CYCLES-1 and no pass/fail condition holds that cycle.
REQ-025 Simultaneous verdict and timeout in the same cycle: pass/fail SHALL win.
REQ-026 If PASS_PAT equals FAIL_PAT, PASS SHALL win.
REQ-027 Terminal states: outputs registered and sticky; dut_rst=0; cycles frozen; LED changes ignored.
REQ-028 restart in a terminal state: next state HOLD, verdict flags and cycles cleared, stability count cleared.
REQ-029 restart in HOLD or RUN SHALL be ignored.
REQ-030 Exactly one of pass/fail/timeout SHALL be high when done=1; all low when done=0.
REQ-031 Verdict latency: the verdict flag is asserted the cycle after the transition condition is met (registered outputs).

Reset
REQ-032 rst low SHALL asynchronously force state HOLD, hold counter 0, dut_rst=1, done/pass/fail/timeout=0, cycles=0, synchroniser and stability state cleared.
REQ-033 Reset deassertion mid-RUN or in a terminal state SHALL restart the sequence from HOLD with the full RST_CYCLES hold.

Structure
REQ-034 State encoding constants and default PASS_PAT/FAIL_PAT SHALL reside in shared package sopc_test_pkg.
REQ-035 The LED synchroniser plus stability counter SHALL be a sub-module named sopc_led_stable.

Verification
REQ-036 Release rst at t=100ns with led=0 constant -> dut_rst high for 5 cycles, then low; timeout=1 with cycles=249999, pass=fail=0.
REQ-037 led=4'hA held from RUN cycle 100 -> pass=1 with cycles within 100+2(sync)+4(stable)+1 of that cycle; fail=timeout=0.
REQ-038 led toggling 4'hA/4'h0 every 2 cycles -> no verdict until timeout; then led=4'h5 held after restart -> fail=1.
REQ-039 led=4'hA stable exactly on the timeout cycle -> pass=1, timeout=0.
REQ-040 Assert rst low mid-RUN at cycle 1000 -> all outputs reset immediately (asynchronous), dut_rst=1; after release a full 5-cycle HOLD occurs.
REQ-041 restart pulsed in RUN -> ignored; pulsed in PASS -> HOLD, flags and cycles cleared, dut_rst=1 next cycle.
